// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage and the upstream SPI register file.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_OUT   = 16;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    localparam logic [2:0] REG_EN_OUT_LO = 3'd0;
    localparam logic [2:0] REG_EN_OUT_HI = 3'd1;
    localparam logic [2:0] REG_EN_PWM_LO = 3'd2;
    localparam logic [2:0] REG_EN_PWM_HI = 3'd3;
    localparam logic [2:0] REG_DUTY      = 3'd4;

    // Full-scale duty is a true 100 %, not 255/256.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] duty,
                                       input logic [PWM_CNT_W-1:0] cnt);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter; flags the last clk of each PWM period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 wrap,
    output logic                 phase0,
    output logic [PWM_CNT_W-1:0] cnt
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]     prescaler_r;
    logic [PWM_CNT_W-1:0] cnt_r;
    logic                 tick_s;

    assign tick_s = (prescaler_r == PRE_LAST);
    assign wrap   = tick_s && (cnt_r == 8'hFF);
    assign phase0 = (prescaler_r == {PRE_W{1'b0}});
    assign cnt    = cnt_r;

    // Prescaler and period counter; both restart from zero on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r <= {PRE_W{1'b0}};
            cnt_r       <= 8'h00;
        end else begin
            prescaler_r <= tick_s ? {PRE_W{1'b0}} : prescaler_r + PRE_W'(1);
            cnt_r       <= tick_s ? cnt_r + 8'd1 : cnt_r;
        end
    end

endmodule

// File: rtl/pwm_out_stage.sv
// Drives 16 pins low, high or with a shared PWM waveform; configuration is
// captured into shadow registers only at period boundaries.
module pwm_out_stage
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         en_reg_out_7_0,
    input  logic [7:0]         en_reg_out_15_8,
    input  logic [7:0]         en_reg_pwm_7_0,
    input  logic [7:0]         en_reg_pwm_15_8,
    input  logic [7:0]         pwm_duty_cycle,
    output logic [NUM_OUT-1:0] out,
    output logic               period_start
);

    logic                 wrap_s;
    logic                 phase0_s;
    logic [PWM_CNT_W-1:0] cnt_s;
    logic                 load_s;
    logic                 pwm_hi_s;
    logic                 period_start_next_s;
    logic [NUM_OUT-1:0]   out_next_s;

    logic                 load_pending_r;
    logic                 loaded_r;
    logic [NUM_OUT-1:0]   shadow_en_out_r;
    logic [NUM_OUT-1:0]   shadow_en_pwm_r;
    logic [PWM_CNT_W-1:0] shadow_duty_r;
    logic [NUM_OUT-1:0]   out_r;
    logic                 period_start_r;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrap   (wrap_s),
        .phase0 (phase0_s),
        .cnt    (cnt_s)
    );

    assign load_s = wrap_s || load_pending_r;

    // Next pin levels and the period marker, computed from the current shadows.
    always_comb begin
        out_next_s = {NUM_OUT{1'b0}};
        pwm_hi_s   = pwm_level(shadow_duty_r, cnt_s);
        for (int i = 0; i < NUM_OUT; i++) begin
            out_next_s[i] = shadow_en_out_r[i] ? (shadow_en_pwm_r[i] ? pwm_hi_s : 1'b1) : 1'b0;
        end
        // The first output cycle after the post-reset load also opens a period.
        period_start_next_s = !load_pending_r &&
                              (loaded_r || ((cnt_s == 8'h00) && phase0_s));
    end

    // Shadow capture, load bookkeeping and the registered pin drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_pending_r  <= 1'b1;
            loaded_r        <= 1'b0;
            shadow_en_out_r <= 16'h0000;
            shadow_en_pwm_r <= 16'h0000;
            shadow_duty_r   <= 8'h00;
            out_r           <= 16'h0000;
            period_start_r  <= 1'b0;
        end else begin
            load_pending_r <= 1'b0;
            loaded_r       <= load_pending_r;
            if (load_s) begin
                shadow_en_out_r <= {en_reg_out_15_8, en_reg_out_7_0};
                shadow_en_pwm_r <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
                shadow_duty_r   <= pwm_duty_cycle;
            end
            out_r          <= out_next_s;
            period_start_r <= period_start_next_s;
        end
    end

    assign out          = out_r;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_out_stage.sv
// Directed bench for pwm_out_stage: an edge-count model checked every cycle,
// plus literal high-time and period measurements.
module tb_pwm_out_stage;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_out_lo = 8'h00, en_out_hi = 8'h00;
    logic [7:0]  en_pwm_lo = 8'h00, en_pwm_hi = 8'h00;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out;
    logic        period_start;

    int vectors = 0;
    int fails   = 0;

    pwm_out_stage #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n counts edges since reset release; output at edge n reflects timebase
    // position n-1 and the configuration captured at edge 1 or the last multiple of PERIOD.
    int          n = 0;
    bit          started = 1'b0;
    logic [15:0] m_en_out, m_en_pwm, exp_out;
    logic [7:0]  m_duty;
    logic        exp_ps;

    always @(posedge clk) begin
        int  pos;
        int  cnt;
        logic hi;
        started = 1'b1;
        if (!rst_n) begin
            n = 0; m_en_out = 16'h0; m_en_pwm = 16'h0; m_duty = 8'h0;
            exp_out = 16'h0; exp_ps = 1'b0;
        end else begin
            n   = n + 1;
            pos = n - 1;
            cnt = (pos / CLK_DIV) % 256;
            hi  = (m_duty == 8'hFF) || (cnt < int'(m_duty));
            for (int i = 0; i < 16; i++)
                exp_out[i] = m_en_out[i] ? (m_en_pwm[i] ? hi : 1'b1) : 1'b0;
            exp_ps = (n == 2) || (n > 1 && (pos % PERIOD) == 0);
            if (n == 1 || (n % PERIOD) == 0) begin
                m_en_out = {en_out_hi, en_out_lo};
                m_en_pwm = {en_pwm_hi, en_pwm_lo};
                m_duty   = duty;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out", {16'h0, out}, {16'h0, exp_out});
            chk("model_period_start", {31'h0, period_start}, {31'h0, exp_ps});
        end
    end

    // Per-period measurement of one pin: length and high count between pulses.
    int meas_pin = 0;
    int len = 0, hi_cnt = 0, last_len = 0, last_hi = 0;

    always @(negedge clk) begin
        if (period_start) begin
            last_len = len; last_hi = hi_cnt;
            len = 1; hi_cnt = int'(out[meas_pin]);
        end else begin
            len++; hi_cnt += int'(out[meas_pin]);
        end
    end

    task automatic wait_ps();
        bit seen = 1'b0;
        for (int i = 0; i < PERIOD + 64 && !seen; i++) begin
            @(negedge clk);
            seen = period_start;
        end
        if (!seen) begin
            vectors++; fails++;
            $display("FAIL wait_period_start: no pulse within %0d clks", PERIOD + 64);
        end
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        {en_out_hi, en_out_lo} = eo;
        {en_pwm_hi, en_pwm_lo} = ep;
        duty = d;
    endtask

    initial begin
        set_cfg(16'hFFFF, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        chk("reset_out", {16'h0, out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_edge1_out", {16'h0, out}, 32'h0);
        chk("rel_edge1_ps", {31'h0, period_start}, 32'h0);
        @(negedge clk);
        chk("rel_edge2_out", {16'h0, out}, 32'hFFFF);
        chk("rel_edge2_ps", {31'h0, period_start}, 32'h1);

        // Mixed pins with 50 % PWM on pin 0.
        set_cfg(16'h00FF, 16'h0001, 8'h80);
        wait_ps();
        wait_ps();
        chk("duty80_len", last_len, PERIOD);
        chk("duty80_hi", last_hi, 1664);
        chk("static_pins", {16'h0, out & 16'hFFFE}, 32'h00FE);

        // Disabled pin ignores its PWM select.
        set_cfg(16'h00F7, 16'h0009, 8'h80);
        meas_pin = 3;
        wait_ps();
        wait_ps();
        chk("en_out_override_hi", last_hi, 0);
        meas_pin = 0;

        // Duty 0x00: constant low for three periods.
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps();
        for (int p = 0; p < 3; p++) begin
            wait_ps();
            chk("duty00_hi", last_hi, 0);
        end

        // Duty 0xFF: constant high across the wrap.
        duty = 8'hFF;
        wait_ps();
        for (int p = 0; p < 2; p++) begin
            wait_ps();
            chk("dutyFF_hi", last_hi, PERIOD);
        end

        // Mid-period duty change only takes effect at the next period.
        duty = 8'h40;
        wait_ps();
        repeat (100 * CLK_DIV) @(negedge clk);
        duty = 8'hC0;
        wait_ps();
        chk("mid_change_old_hi", last_hi, 832);
        wait_ps();
        chk("mid_change_new_hi", last_hi, 2496);

        // One-clk reset at cnt=50 restarts the timebase and reloads shadows.
        wait_ps();
        repeat (50 * CLK_DIV) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", {16'h0, out}, 32'h0);
        chk("midrst_ps", {31'h0, period_start}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_edge1_out", {16'h0, out}, 32'h0);
        @(negedge clk);
        chk("midrst_edge2_out", {16'h0, out}, 32'hFFFF);
        chk("midrst_edge2_ps", {31'h0, period_start}, 32'h1);
        wait_ps();
        wait_ps();
        chk("post_rst_len", last_len, PERIOD);
        chk("post_rst_hi", last_hi, 2496);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
